// File: rtl/pipelined_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings and a
// log2 helper for sizing shift-amount fields.
package pipelined_shifter_pkg;

  typedef enum logic [2:0] {
    ModeSll = 3'b000,
    ModeSrl = 3'b001,
    ModeSra = 3'b010,
    ModeRol = 3'b011,
    ModeRor = 3'b100
  } mode_e;

  localparam int unsigned ShamtPortWidth = 32;

  function automatic int unsigned log2_floor(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = value; v > 1; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/pipelined_shifter_shift_stage.sv
// One pipeline stage: conditionally shifts/rotates by 2^K positions, then registers the
// data and its side-band fields; everything holds while en_i is low.
module shift_stage
  import pipelined_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LOG2W = 5,
  parameter int unsigned K     = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [2:0]       mode_i,
  input  logic [LOG2W-1:0] shamt_i,
  input  logic             sat_i,
  input  logic             sign_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [2:0]       mode_o,
  output logic [LOG2W-1:0] shamt_o,
  output logic             sat_o,
  output logic             sign_o
);

  localparam int unsigned Amt = 1 << K;
  localparam logic [WIDTH-1:0] HiMask = ~({WIDTH{1'b1}} >> Amt);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q, shifted;
  logic [2:0]       mode_d, mode_q;
  logic [LOG2W-1:0] shamt_d, shamt_q;
  logic             sat_d, sat_q;
  logic             sign_d, sign_q;
  logic             load;

  always_comb begin
    shifted = data_i;
    if (shamt_i[K]) begin
      case (mode_i)
        ModeSll: shifted = data_i << Amt;
        ModeSrl: shifted = data_i >> Amt;
        ModeSra: shifted = (data_i >> Amt) | (sign_i ? HiMask : '0);
        ModeRol: shifted = (data_i << Amt) | (data_i >> (WIDTH - Amt));
        ModeRor: shifted = (data_i >> Amt) | (data_i << (WIDTH - Amt));
        default: shifted = data_i;
      endcase
    end
  end

  // Payload only loads with a valid op so Y never moves while out_valid is low.
  always_comb begin
    load    = en_i & valid_i;
    valid_d = en_i ? valid_i : valid_q;
    data_d  = load ? shifted : data_q;
    mode_d  = load ? mode_i  : mode_q;
    shamt_d = load ? shamt_i : shamt_q;
    sat_d   = load ? sat_i   : sat_q;
    sign_d  = load ? sign_i  : sign_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= '0;
      shamt_q <= '0;
      sat_q   <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      shamt_q <= shamt_d;
      sat_q   <= sat_d;
      sign_q  <= sign_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign mode_o  = mode_q;
  assign shamt_o = shamt_q;
  assign sat_o   = sat_q;
  assign sign_o  = sign_q;

endmodule

// File: rtl/pipelined_shifter.sv
// LOG2W-stage pipelined barrel shifter with valid/ready handshake; saturation of
// out-of-range shift amounts is applied at the output from the carried flag.
module pipelined_shifter
  import pipelined_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LOG2W = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          D,
  input  logic [ShamtPortWidth-1:0] S,
  input  logic [2:0]                MODE,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          Y
);

  logic             valid_s [LOG2W+1];
  logic [WIDTH-1:0] data_s  [LOG2W+1];
  logic [2:0]       mode_s  [LOG2W+1];
  logic [LOG2W-1:0] shamt_s [LOG2W+1];
  logic             sat_s   [LOG2W+1];
  logic             sign_s  [LOG2W+1];
  logic             advance;

  assign advance    = out_ready | ~out_valid;
  assign in_ready   = advance & ~RST;

  assign valid_s[0] = in_valid & in_ready;
  assign data_s[0]  = D;
  assign mode_s[0]  = MODE;
  assign shamt_s[0] = S[LOG2W-1:0];
  assign sat_s[0]   = |S[ShamtPortWidth-1:LOG2W];
  assign sign_s[0]  = D[WIDTH-1];

  for (genvar k = 0; k < LOG2W; k++) begin : g_stage
    shift_stage #(
      .WIDTH(WIDTH),
      .LOG2W(LOG2W),
      .K    (k)
    ) u_stage (
      .clk_i  (CLK),
      .rst_i  (RST),
      .en_i   (advance),
      .valid_i(valid_s[k]),
      .data_i (data_s[k]),
      .mode_i (mode_s[k]),
      .shamt_i(shamt_s[k]),
      .sat_i  (sat_s[k]),
      .sign_i (sign_s[k]),
      .valid_o(valid_s[k+1]),
      .data_o (data_s[k+1]),
      .mode_o (mode_s[k+1]),
      .shamt_o(shamt_s[k+1]),
      .sat_o  (sat_s[k+1]),
      .sign_o (sign_s[k+1])
    );
  end

  // Rotates ignore saturation: they only ever use S mod WIDTH.
  always_comb begin
    out_valid = valid_s[LOG2W];
    Y         = data_s[LOG2W];
    if (sat_s[LOG2W]) begin
      case (mode_s[LOG2W])
        ModeSll, ModeSrl: Y = '0;
        ModeSra:          Y = {WIDTH{sign_s[LOG2W]}};
        default:          Y = data_s[LOG2W];
      endcase
    end
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter at WIDTH=32: directed vectors, backpressure,
// streaming against a reference model, and mid-flight reset.
module tb_pipelined_shifter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] D;
  logic [31:0] S;
  logic [2:0]  MODE;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Y;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [31:0] exp_q[$];
  int          pop_cyc[$];

  localparam logic [2:0] SLL = 3'd0, SRL = 3'd1, SRA = 3'd2, ROL = 3'd3, ROR = 3'd4;
  localparam logic [2:0] PASS = 3'd5;

  pipelined_shifter #(
    .WIDTH(32),
    .LOG2W(5)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .D        (D),
    .S        (S),
    .MODE     (MODE),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Y        (Y)
  );

  always #5 CLK = ~CLK;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic [31:0] s,
                                        input logic [2:0] m);
    int unsigned r;
    r = s % 32;
    case (m)
      SLL: return (s >= 32) ? 32'h0 : d << s;
      SRL: return (s >= 32) ? 32'h0 : d >> s;
      SRA: return (s >= 32) ? {32{d[31]}} : 32'($signed(d) >>> s);
      ROL: return (r == 0) ? d : (d << r) | (d >> (32 - r));
      ROR: return (r == 0) ? d : (d >> r) | (d << (32 - r));
      default: return d;
    endcase
  endfunction

  // Monitor: transfers happen at the next rising edge when valid and ready are both high.
  initial begin
    forever begin
      @(negedge CLK);
      #2;
      cyc++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got Y=%h with nothing outstanding", Y);
        end else begin
          check32("result", Y, exp_q.pop_front());
        end
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic issue(input logic [31:0] d, input logic [31:0] s, input logic [2:0] m,
                       input logic [31:0] e);
    @(negedge CLK);
    D = d; S = s; MODE = m; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (in_ready === 1'b1) begin
        exp_q.push_back(e);
        return;
      end
      @(negedge CLK);
    end
    check32("issue_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic drain();
    @(negedge CLK);
    in_valid = 1'b0;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge CLK);
    repeat (2) @(negedge CLK);
    check32("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int lat;
    int p0;
    int seen;
    logic [31:0] rd, rs;
    logic [2:0]  rm;

    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1; D = '0; S = '0; MODE = '0;
    @(negedge CLK);
    #1;
    check32("in_ready_in_reset", 32'(in_ready), 32'd0);
    @(negedge CLK);
    #1;
    check32("reset_out_valid", 32'(out_valid), 32'd0);
    check32("reset_Y", Y, 32'h0);
    RST = 1'b0;

    // Latency: accepted edge t, visible after edge t+4.
    issue(32'h0000_0001, 32'd4, SLL, 32'h0000_0010);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      in_valid = 1'b0;
      #1;
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    check32("latency", 32'(lat), 32'd5);
    drain();

    issue(32'h8000_0000, 32'd31,    SRL,  32'h0000_0001);
    issue(32'h8000_0000, 32'd40,    SRA,  32'hFFFF_FFFF);
    issue(32'h8000_0000, 32'd40,    SRL,  32'h0000_0000);
    issue(32'hFFFF_FFFF, 32'h100,   SLL,  32'h0000_0000);
    issue(32'h0000_00FF, 32'd8,     ROR,  32'hFF00_0000);
    issue(32'h1234_5678, 32'd36,    ROL,  32'h2345_6781);
    issue(32'h8000_0000, 32'd0,     SRA,  32'h8000_0000);
    issue(32'h8000_0000, 32'd4,     SRA,  32'hF800_0000);
    issue(32'hDEAD_BEEF, 32'd32,    ROR,  32'hDEAD_BEEF);
    issue(32'hDEAD_BEEF, 32'd7,     PASS, 32'hDEAD_BEEF);
    issue(32'h1234_5678, 32'hFFFF_FFFF, 3'd7, 32'h1234_5678);
    drain();

    // Backpressure: five ops fill the pipe, consumer stalls three cycles.
    out_ready = 1'b0;
    p0 = pop_cyc.size();
    issue(32'h0000_0001, 32'd1, SLL, 32'h0000_0002);
    issue(32'h0000_00F0, 32'd4, SRL, 32'h0000_000F);
    issue(32'h8000_0000, 32'd4, SRA, 32'hF800_0000);
    issue(32'h8000_0001, 32'd1, ROL, 32'h0000_0003);
    issue(32'h0000_0003, 32'd1, ROR, 32'h8000_0001);
    @(negedge CLK);
    D = 32'hCAFE_BABE; S = 32'd3; MODE = PASS; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check32("stall_in_ready", 32'(in_ready), 32'd0);
      check32("stall_out_valid", 32'(out_valid), 32'd1);
      check32("stall_Y", Y, 32'h0000_0002);
      @(negedge CLK);
    end
    out_ready = 1'b1;
    #1;
    check32("release_in_ready", 32'(in_ready), 32'd1);
    if (in_ready === 1'b1) exp_q.push_back(32'hCAFE_BABE);
    drain();
    check32("bp_result_count", 32'(pop_cyc.size() - p0), 32'd6);

    // Streaming: 100 back-to-back random ops, one result per cycle.
    p0 = pop_cyc.size();
    for (int i = 0; i < 100; i++) begin
      rd = $urandom;
      rs = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      rm = 3'($urandom_range(0, 7));
      issue(rd, rs, rm, model(rd, rs, rm));
    end
    drain();
    check32("stream_count", 32'(pop_cyc.size() - p0), 32'd100);
    if (pop_cyc.size() >= p0 + 100)
      check32("stream_span", 32'(pop_cyc[p0+99] - pop_cyc[p0]), 32'd99);

    // Reset with three operations in flight.
    issue(32'h0000_0001, 32'd2, SLL, 32'h0000_0004);
    issue(32'h0000_0010, 32'd1, SRL, 32'h0000_0008);
    issue(32'h0000_0001, 32'd1, ROR, 32'h8000_0000);
    @(negedge CLK);
    RST = 1'b1; in_valid = 1'b0;
    exp_q.delete();
    #1;
    check32("midreset_in_ready", 32'(in_ready), 32'd0);
    @(negedge CLK);
    #1;
    check32("midreset_out_valid", 32'(out_valid), 32'd0);
    check32("midreset_Y", Y, 32'h0);
    RST = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    check32("no_stale_result", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
